dcj11_bus_master: RTL and testbench

- Bus-cycle initiator that emulates the DCJ11 side of the multiplexed DAL/AIO bus (ALE_n, SCTL_n, BUFCTL_n).
- Lets the memory/UART/tape responder be exercised without a CPU fitted, either in the FPGA self-test build or in simulation.
- Accepts one transaction command at a time and sequences address, data and strobe phases with parameterised cycle timing.
- Returns the read data, or a write completion, on a response strobe.

---
 rtl/dcj11_bus_pkg.sv | 34 +++
 rtl/dcj11_bus_master.sv | 192 +++++++++++++++++++
 tb/tb_dcj11_bus_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcj11_bus_pkg.sv
// Shared DCJ11 bus definitions: AIO cycle codes, bus-master state encoding
// and cycle classification, reused by the responder decode.
package dcj11_bus_pkg;

  localparam logic [3:0] NONIO        = 4'b1111;
  localparam logic [3:0] GPREAD       = 4'b1110;
  localparam logic [3:0] INTACK       = 4'b1101;
  localparam logic [3:0] IREADRQ      = 4'b1100;
  localparam logic [3:0] RMWNBL       = 4'b1011;
  localparam logic [3:0] RMWBL        = 4'b1010;
  localparam logic [3:0] DREAD        = 4'b1001;
  localparam logic [3:0] IREADDM      = 4'b1000;
  localparam logic [3:0] GPWRITE      = 4'b0101;
  localparam logic [3:0] BUSBYTEWRITE = 4'b0011;
  localparam logic [3:0] BUSWORDWRITE = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_AHOLD = 3'd2,
    S_DATA  = 3'd3,
    S_STRB  = 3'd4,
    S_REC   = 3'd5
  } bus_state_t;

  function automatic logic is_write(input logic [3:0] code);
    return (code == BUSBYTEWRITE) || (code == BUSWORDWRITE) || (code == GPWRITE);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dcj11_bus_master.sv
// DCJ11-side DAL/AIO bus-cycle initiator: runs one command at a time through
// address, address-hold, data, strobe and recovery phases.
module dcj11_bus_master
  import dcj11_bus_pkg::*;
#(
  parameter int T_ASU  = 2,
  parameter int T_AHLD = 2,
  parameter int T_DSU  = 3,
  parameter int T_SCTL = 4,
  parameter int T_REC  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_aio,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [15:0] dal_out,
  output logic        dal_oe,
  input  logic [15:0] dal_in,
  output logic [3:0]  aio,
  output logic        ale_n,
  output logic        sctl_n,
  output logic        bufctl_n
);

  localparam int T_MAX = max_int(max_int(max_int(T_ASU, T_AHLD), max_int(T_DSU, T_SCTL)), T_REC);
  localparam int CW    = $clog2(T_MAX + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  if (T_ASU < 1 || T_AHLD < 1 || T_DSU < 1 || T_SCTL < 1 || T_REC < 1) begin : g_param_check
    $error("dcj11_bus_master: all phase timing parameters must be at least 1");
  end

  bus_state_t  state_reg, state_next;
  cnt_t        cnt_reg, cnt_next;
  logic [3:0]  aio_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        write_reg;

  logic        accept;
  logic        phase_done;
  logic        capture_read;
  logic [15:0] write_data;

  assign accept       = (state_reg == S_IDLE) && cmd_valid && cmd_ready;
  assign phase_done   = (cnt_reg == CNT_ONE);
  assign capture_read = (state_reg == S_STRB) && phase_done && !write_reg;
  // Byte writes replicate the low byte so the responder finds it on either lane.
  assign write_data   = (aio_reg == BUSBYTEWRITE) ? {wdata_reg[7:0], wdata_reg[7:0]} : wdata_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_ADDR;
          cnt_next   = cnt_t'(T_ASU);
        end
      end
      S_ADDR: begin
        if (phase_done) begin
          state_next = S_AHOLD;
          cnt_next   = cnt_t'(T_AHLD);
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      S_AHOLD: begin
        if (phase_done) begin
          state_next = S_DATA;
          cnt_next   = cnt_t'(T_DSU);
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      S_DATA: begin
        if (phase_done) begin
          state_next = S_STRB;
          cnt_next   = cnt_t'(T_SCTL);
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      S_STRB: begin
        if (phase_done) begin
          state_next = S_REC;
          cnt_next   = cnt_t'(T_REC);
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      S_REC: begin
        if (phase_done) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so every pin is a flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      aio_reg   <= NONIO;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      dal_out   <= '0;
      dal_oe    <= 1'b0;
      aio       <= NONIO;
      ale_n     <= 1'b1;
      sctl_n    <= 1'b1;
      bufctl_n  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rsp_valid <= 1'b0;

      if (accept) begin
        aio_reg   <= cmd_aio;
        addr_reg  <= cmd_addr;
        wdata_reg <= cmd_wdata;
        write_reg <= is_write(cmd_aio);
      end

      if (capture_read) begin
        rsp_rdata <= dal_in;
      end

      case (state_next)
        S_ADDR, S_AHOLD: begin
          cmd_ready <= 1'b0;
          dal_oe    <= 1'b1;
          dal_out   <= accept ? cmd_addr : addr_reg;
          aio       <= accept ? cmd_aio : aio_reg;
          ale_n     <= (state_next != S_AHOLD);
          sctl_n    <= 1'b1;
          bufctl_n  <= 1'b1;
        end
        S_DATA, S_STRB: begin
          // Reads release DAL in the same cycle the responder buffer turns on.
          cmd_ready <= 1'b0;
          dal_oe    <= write_reg;
          dal_out   <= write_reg ? write_data : 16'h0000;
          aio       <= aio_reg;
          ale_n     <= 1'b0;
          sctl_n    <= (state_next != S_STRB);
          bufctl_n  <= write_reg;
        end
        S_REC: begin
          cmd_ready <= 1'b0;
          rsp_valid <= (state_reg == S_STRB);
          dal_oe    <= 1'b0;
          dal_out   <= '0;
          aio       <= NONIO;
          ale_n     <= 1'b1;
          sctl_n    <= 1'b1;
          bufctl_n  <= 1'b1;
        end
        default: begin
          cmd_ready <= 1'b1;
          dal_oe    <= 1'b0;
          dal_out   <= '0;
          aio       <= NONIO;
          ale_n     <= 1'b1;
          sctl_n    <= 1'b1;
          bufctl_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcj11_bus_master.sv
// Scoreboard bench for dcj11_bus_master with a small behavioural DAL responder
// (word memory, power-up GP config word, UART transmit register).
module tb_dcj11_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_aio;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] dal_out;
  logic        dal_oe;
  logic [15:0] dal_in;
  logic [3:0]  aio;
  logic        ale_n;
  logic        sctl_n;
  logic        bufctl_n;

  dcj11_bus_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_aio   (cmd_aio),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .dal_out   (dal_out),
    .dal_oe    (dal_oe),
    .dal_in    (dal_in),
    .aio       (aio),
    .ale_n     (ale_n),
    .sctl_n    (sctl_n),
    .bufctl_n  (bufctl_n)
  );

  typedef struct {
    logic        is_rd;
    logic [15:0] rdata;
    logic [15:0] dal;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          acc_hist[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rsp_count = 0;

  logic [15:0] mem [0:1023];
  logic [15:0] lat_addr = 16'h0;
  logic [3:0]  lat_aio = 4'hF;
  logic [15:0] rd_val = 16'h0;
  logic [7:0]  uart_tx = 8'h00;
  logic        prev_ale = 1'b1;
  logic        prev_sctl = 1'b1;
  logic        prev_buf = 1'b1;
  int          ale_off = -1;
  int          buf_off = -1;
  int          sctl_cnt = 0;
  logic [15:0] strb_dal = 16'h0;

  assign dal_in = bufctl_n ? 16'hDEAD : rd_val;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Responder model plus protocol monitor, sampled on the falling edge.
  initial forever begin
    exp_t e;
    int   a;
    logic lat_wr;
    @(negedge clk);
    if (!reset_n) begin
      acc_q.delete();
      ale_off   = -1;
      buf_off   = -1;
      sctl_cnt  = 0;
      prev_ale  = 1'b1;
      prev_sctl = 1'b1;
      prev_buf  = 1'b1;
    end else begin
      chk("oe_and_bufctl_exclusive", {31'b0, dal_oe & ~bufctl_n}, 32'd0);
      chk("ready_low_when_busy", {31'b0, cmd_ready & (dal_oe | ~ale_n | ~sctl_n | ~bufctl_n | rsp_valid)}, 32'd0);

      if (prev_ale && !ale_n) begin
        lat_addr = dal_out;
        lat_aio  = aio;
        rd_val   = (aio == 4'b1110) ? ((dal_out[8:0] == 9'd0) ? 16'h0003 : 16'h0000)
                                    : mem[dal_out[10:1]];
        if (acc_q.size() > 0) ale_off = cyc - acc_q[0];
      end
      if (prev_buf && !bufctl_n && acc_q.size() > 0) buf_off = cyc - acc_q[0];

      lat_wr = (lat_aio == 4'b0011) || (lat_aio == 4'b0001) || (lat_aio == 4'b0101);
      if (!sctl_n) begin
        sctl_cnt++;
        strb_dal = dal_oe ? dal_out : 16'h0BAD;
      end
      if (prev_sctl && !sctl_n && lat_wr) begin
        if (lat_addr == 16'o177566) uart_tx = dal_out[7:0];
        else if (lat_aio == 4'b0011) begin
          if (lat_addr[0]) mem[lat_addr[10:1]][15:8] = dal_out[15:8];
          else             mem[lat_addr[10:1]][7:0]  = dal_out[7:0];
        end else if (lat_aio == 4'b0001) mem[lat_addr[10:1]] = dal_out;
      end

      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(cyc);
        acc_hist.push_back(cyc);
      end

      if (rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1, required no pending command");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp_latency", cyc - a, 32'd12);
          chk("ale_fall_offset", ale_off, 32'd3);
          chk("sctl_low_cycles", sctl_cnt, 32'd4);
          if (e.is_rd) begin
            chk("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, e.rdata});
            chk("bufctl_fall_offset", buf_off, 32'd5);
          end else begin
            chk("strb_dal", {16'h0, strb_dal}, {16'h0, e.dal});
          end
        end
        ale_off  = -1;
        buf_off  = -1;
        sctl_cnt = 0;
      end
      prev_ale  = ale_n;
      prev_sctl = sctl_n;
      prev_buf  = bufctl_n;
    end
  end

  // Called at posedge+1; leaves cmd_valid high when keep is set.
  task automatic issue(input logic [3:0] code, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic is_rd, input logic [15:0] exp_rd, input logic [15:0] exp_dal,
                       input logic keep, input logic push);
    int   n;
    exp_t e;
    n = 0;
    cmd_aio   = code;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (push) begin
        e.is_rd = is_rd;
        e.rdata = exp_rd;
        e.dal   = exp_dal;
        exp_q.push_back(e);
      end
      if (!keep) cmd_valid = 1'b0;
      $display("cmd aio=%b addr=%o wdata=%h accepted at cycle %0d", code, addr, wdata, cyc - 1);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("response_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int idx;
    int n;
    int rc;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_aio   = 4'h0;
    cmd_addr  = 16'h0;
    cmd_wdata = 16'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_aio   = 4'b0001;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'd0);
    chk("rst_dal_out", {16'h0, dal_out}, 32'd0);
    chk("rst_dal_oe", {31'b0, dal_oe}, 32'd0);
    chk("rst_aio", {28'h0, aio}, 32'hF);
    chk("rst_strobes", {29'b0, ale_n, sctl_n, bufctl_n}, 32'd7);
    @(posedge clk);
    #1;
    chk("no_accept_during_reset", {31'b0, dal_oe}, 32'd0);
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {31'b0, cmd_ready}, 32'd1);

    // Word write, then read back
    issue(4'b0001, 16'o001000, 16'h1234, 1'b0, 16'h0, 16'h1234, 1'b0, 1'b1);
    wait_done();
    chk("mem_word_001000", {16'h0, mem[16'o001000 >> 1]}, 32'h1234);
    issue(4'b1001, 16'o001000, 16'h0, 1'b1, 16'h1234, 16'h0, 1'b0, 1'b1);
    wait_done();

    // Byte write to the odd byte replicates onto both lanes
    issue(4'b0011, 16'o001001, 16'h00AB, 1'b0, 16'h0, 16'hABAB, 1'b0, 1'b1);
    wait_done();
    issue(4'b1001, 16'o001000, 16'h0, 1'b1, 16'hAB34, 16'h0, 1'b0, 1'b1);
    wait_done();

    // GP read of power-up config, then UART transmit
    issue(4'b1110, 16'o000000, 16'h0, 1'b1, 16'h0003, 16'h0, 1'b0, 1'b1);
    wait_done();
    issue(4'b0011, 16'o177566, 16'h0041, 1'b0, 16'h0, 16'h4141, 1'b0, 1'b1);
    wait_done();
    chk("uart_tx_char", {24'h0, uart_tx}, 32'h41);

    // Back-to-back with cmd_valid held high
    idx = acc_hist.size();
    issue(4'b0001, 16'o001002, 16'h5555, 1'b0, 16'h0, 16'h5555, 1'b1, 1'b1);
    issue(4'b0011, 16'o001005, 16'h0077, 1'b0, 16'h0, 16'h7777, 1'b1, 1'b1);
    issue(4'b1001, 16'o001004, 16'h0, 1'b1, 16'h7700, 16'h0, 1'b0, 1'b1);
    wait_done();
    if (acc_hist.size() >= idx + 3) begin
      chk("b2b_spacing_1", acc_hist[idx + 1] - acc_hist[idx], 32'd14);
      chk("b2b_spacing_2", acc_hist[idx + 2] - acc_hist[idx + 1], 32'd14);
    end else begin
      chk("b2b_accept_count", acc_hist.size() - idx, 32'd3);
    end
    chk("mem_word_001002", {16'h0, mem[16'o001002 >> 1]}, 32'h5555);

    // Reset during the strobe phase of a write
    repeat (2) @(posedge clk);
    #1;
    rc = rsp_count;
    issue(4'b0001, 16'o001010, 16'hBEEF, 1'b0, 16'h0, 16'hBEEF, 1'b0, 1'b0);
    n = 0;
    while (sctl_n && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_strobe", {31'b0, sctl_n}, 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_sctl_n", {31'b0, sctl_n}, 32'd1);
    chk("abort_ale_n", {31'b0, ale_n}, 32'd1);
    chk("abort_dal_oe", {31'b0, dal_oe}, 32'd0);
    chk("abort_aio", {28'h0, aio}, 32'hF);
    chk("abort_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_abort", {31'b0, cmd_ready}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("no_rsp_after_abort", rsp_count, rc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
